// File: rtl/iz_param_loader.sv
// iz_param_loader
// Byte-serial loader for the Izhikevich neuron a/b/c/d parameter set.
// A frame has the form HEADER, eight data bytes (big-endian a,b,c,d), then an
// XOR checksum of the data bytes. The shadow set is committed to the outputs
// on a single edge only when the checksum matches, so the neuron never sees a
// partial set. While a frame is in flight the neuron is paused (params_ready low).
module iz_param_loader #(
    parameter logic [7:0]         HEADER         = 8'hA5,
    parameter int unsigned        TIMEOUT_CYCLES = 255,
    parameter logic signed [15:0] DEF_A          = 16'sd1,
    parameter logic signed [15:0] DEF_B          = 16'sd13,
    parameter logic signed [15:0] DEF_C          = -16'sd4160,
    parameter logic signed [15:0] DEF_D          = 16'sd512,
    parameter bit                 DEFAULTS_VALID = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        load_busy,
    output logic        frame_done,
    output logic        load_error
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_DATA   = 2'd1;
    localparam logic [1:0]  ST_CSUM   = 2'd2;
    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

    // Running checksum: plain XOR of every data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        csum_update = acc ^ b;
    endfunction

    logic [1:0]  state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [7:0]  csum_r, csum_s;
    logic [15:0] tmo_r, tmo_s;
    logic [16:0] tmo_inc_s;
    logic        valid_r, valid_s;
    logic        err_s;
    logic        shadow_we_s;
    logic        commit_s;
    logic [7:0]  shadow_r [0:7];

    logic [15:0] param_a_r, param_b_r, param_c_r, param_d_r;
    logic        params_ready_r, load_busy_r, frame_done_r, load_error_r;

    assign tmo_inc_s = {1'b0, tmo_r} + 17'd1;

    // Next-state decode for the frame parser, checksum and idle timeout.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        csum_s      = csum_r;
        tmo_s       = tmo_r;
        valid_s     = valid_r;
        err_s       = load_error_r;
        shadow_we_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_valid && (load_data == HEADER)) begin
                    state_s = ST_DATA;
                    cnt_s   = 3'd0;
                    csum_s  = 8'h00;
                    tmo_s   = 16'd0;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (load_valid) begin
                    shadow_we_s = 1'b1;
                    csum_s      = csum_update(csum_r, load_data);
                    cnt_s       = cnt_r + 3'd1;
                    tmo_s       = 16'd0;
                    if (cnt_r == 3'd7) begin
                        state_s = ST_CSUM;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    state_s = ST_IDLE;
                    tmo_s   = 16'd0;
                    err_s   = 1'b1;
                end else begin
                    tmo_s = tmo_inc_s[15:0];
                end
            end
            ST_CSUM: begin
                if (load_valid) begin
                    state_s = ST_IDLE;
                    tmo_s   = 16'd0;
                    if (load_data == csum_r) begin
                        commit_s = 1'b1;
                        valid_s  = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    state_s = ST_IDLE;
                    tmo_s   = 16'd0;
                    err_s   = 1'b1;
                end else begin
                    tmo_s = tmo_inc_s[15:0];
                end
            end
            default: begin
                state_s = ST_IDLE;
                tmo_s   = 16'd0;
            end
        endcase
    end

    // Control state and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 3'd0;
            csum_r         <= 8'h00;
            tmo_r          <= 16'd0;
            valid_r        <= DEFAULTS_VALID;
            params_ready_r <= DEFAULTS_VALID;
            load_busy_r    <= 1'b0;
            frame_done_r   <= 1'b0;
            load_error_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            csum_r         <= csum_s;
            tmo_r          <= tmo_s;
            valid_r        <= valid_s;
            params_ready_r <= valid_s && (state_s == ST_IDLE);
            load_busy_r    <= (state_s == ST_DATA) || (state_s == ST_CSUM);
            frame_done_r   <= commit_s;
            load_error_r   <= err_s;
        end
    end

    // Shadow byte store; the byte counter selects the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else if (shadow_we_s) begin
            shadow_r[cnt_r] <= load_data;
        end else begin
            shadow_r[cnt_r] <= shadow_r[cnt_r];
        end
    end

    // Atomic commit of all four parameters on a good checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            param_a_r <= DEF_A;
            param_b_r <= DEF_B;
            param_c_r <= DEF_C;
            param_d_r <= DEF_D;
        end else if (commit_s) begin
            param_a_r <= {shadow_r[0], shadow_r[1]};
            param_b_r <= {shadow_r[2], shadow_r[3]};
            param_c_r <= {shadow_r[4], shadow_r[5]};
            param_d_r <= {shadow_r[6], shadow_r[7]};
        end else begin
            param_a_r <= param_a_r;
            param_b_r <= param_b_r;
            param_c_r <= param_c_r;
            param_d_r <= param_d_r;
        end
    end

    assign param_a      = param_a_r;
    assign param_b      = param_b_r;
    assign param_c      = param_c_r;
    assign param_d      = param_d_r;
    assign params_ready = params_ready_r;
    assign load_busy    = load_busy_r;
    assign frame_done   = frame_done_r;
    assign load_error   = load_error_r;

endmodule
